// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the shared-memory, single-ALU MIPS multicycle datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback, stalls
// on the memory ready handshake, traps on unknown opcodes and counts retirements.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             link,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JR_EXEC   = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b001000;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_JAL:        state_d = S_JUMP;
          OP_JR:         state_d = S_JR_EXEC;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_JR_EXEC:   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Control decode from the registered state; the ready-qualified strobes are
  // Mealy so the IR/PC/MDR load lands on the exact cycle memory completes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    link          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_retired = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read  = 1'b1;
          i_or_d    = 1'b1;
          mdr_write = mem_ready;
        end
        S_MEM_WB: begin
          reg_write     = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write     = 1'b1;
          i_or_d        = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write     = 1'b1;
          reg_dst       = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_retired = 1'b1;
        end
        S_JUMP: begin
          // PC already holds PC+4 here, so it is the link value.
          pc_write      = 1'b1;
          pc_source     = 2'b10;
          reg_write     = 1'b1;
          link          = 1'b1;
          instr_retired = 1'b1;
        end
        S_JR_EXEC: begin
          pc_write      = 1'b1;
          pc_source     = 2'b11;
          instr_retired = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State register, retirement counter and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_retired) count_q <= count_q + CNT_W'(1);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign state         = state_q;
  assign retired_count = count_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each instruction is expanded
// into its expected per-cycle state/control sequence, queued, then replayed
// against the DUT one cycle at a time.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                         ST_MEM_READ = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WRITE = 4'd5,
                         ST_EXEC_R = 4'd6, ST_R_WB = 4'd7, ST_BRANCH = 4'd8,
                         ST_JUMP = 4'd9, ST_JR_EXEC = 4'd10, ST_TRAP = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_JAL = 6'b000011, OP_JR = 6'b001000,
                         OP_BAD = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_retired;
  } ctrl_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [5:0] opc;
    logic [3:0] st;
    ctrl_t      exp;
  } entry_t;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             ir_write, mdr_write, mem_to_reg, reg_dst, reg_write, link, alu_src_a;
  logic [1:0]       pc_source, alu_src_b, alu_op;
  logic [3:0]       state;
  logic             instr_retired;
  logic [CNT_W-1:0] retired_count;
  logic             illegal_op;

  ctrl_t      got_ctrl;
  entry_t     sb[$];
  logic [3:0] exp_cnt;
  logic       exp_ill;
  int         n_chk;
  int         n_pass;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .link(link),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .instr_retired(instr_retired),
    .retired_count(retired_count), .illegal_op(illegal_op)
  );

  assign got_ctrl = '{pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                      ir_write, mdr_write, mem_to_reg, reg_dst, reg_write, link,
                      alu_src_a, alu_src_b, alu_op, instr_retired};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Expected controls for one state, straight from the state table.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      ST_DECODE:    begin c.alu_src_b = 2'b11; end
      ST_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ST_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; c.mdr_write = rdy; end
      ST_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_retired = 1'b1; end
      ST_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_retired = rdy; end
      ST_EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ST_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_retired = 1'b1; end
      ST_BRANCH:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                          c.pc_source = 2'b01; c.instr_retired = 1'b1; end
      ST_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.reg_write = 1'b1;
                          c.link = 1'b1; c.instr_retired = 1'b1; end
      ST_JR_EXEC:   begin c.pc_write = 1'b1; c.pc_source = 2'b11; c.instr_retired = 1'b1; end
      default:      c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input logic rst, input logic [3:0] st, input logic rdy, input logic [5:0] opc);
    entry_t e;
    e.rst = rst;
    e.st  = st;
    e.rdy = rdy;
    e.opc = opc;
    e.exp = rst ? ctrl_t'('0) : exp_ctrl(st, rdy);
    sb.push_back(e);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction; fw/mw = wait cycles in FETCH / memory state
  // (mw doubles as the number of TRAP cycles for an illegal opcode).
  task automatic enqueue_instr(input logic [5:0] opc, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(1'b0, ST_FETCH, 1'b0, 6'($urandom));
    push(1'b0, ST_FETCH, 1'b1, 6'($urandom));
    push(1'b0, ST_DECODE, rnd_bit(), opc);
    case (opc)
      OP_R: begin
        push(1'b0, ST_EXEC_R, rnd_bit(), opc);
        push(1'b0, ST_R_WB, rnd_bit(), opc);
      end
      OP_LW: begin
        push(1'b0, ST_MEM_ADDR, rnd_bit(), opc);
        for (int i = 0; i < mw; i++) push(1'b0, ST_MEM_READ, 1'b0, opc);
        push(1'b0, ST_MEM_READ, 1'b1, opc);
        push(1'b0, ST_MEM_WB, rnd_bit(), opc);
      end
      OP_SW: begin
        push(1'b0, ST_MEM_ADDR, rnd_bit(), opc);
        for (int i = 0; i < mw; i++) push(1'b0, ST_MEM_WRITE, 1'b0, opc);
        push(1'b0, ST_MEM_WRITE, 1'b1, opc);
      end
      OP_BEQ: push(1'b0, ST_BRANCH, rnd_bit(), opc);
      OP_JAL: push(1'b0, ST_JUMP, rnd_bit(), opc);
      OP_JR:  push(1'b0, ST_JR_EXEC, rnd_bit(), opc);
      default: for (int i = 0; i < mw; i++) push(1'b0, ST_TRAP, rnd_bit(), opc);
    endcase
  endtask

  // Drain the scoreboard: drive one cycle, sample mid-cycle, compare.
  task automatic play();
    entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset     = e.rst;
      opcode    = e.opc;
      mem_ready = e.rdy;
      if (e.st == ST_TRAP && !e.rst) exp_ill = 1'b1;
      @(negedge clk);
      $display("cyc rst=%0b st=%0d rdy=%0b op=%b ctrl=%05h cnt=%0d ill=%0b",
               e.rst, state, e.rdy, e.opc, got_ctrl, retired_count, illegal_op);
      check($sformatf("state(exp st%0d)", e.st), 32'(state), 32'(e.st));
      check($sformatf("ctrl@st%0d rst=%0b", e.st, e.rst), 32'(got_ctrl), 32'(e.exp));
      check($sformatf("retired_count@st%0d", e.st), 32'(retired_count), 32'(exp_cnt));
      check($sformatf("illegal_op@st%0d", e.st), 32'(illegal_op), 32'(exp_ill));
      @(posedge clk);
      #1;
      if (e.rst) begin
        exp_cnt = '0;
        exp_ill = 1'b0;
      end else if (e.exp.instr_retired) begin
        exp_cnt = exp_cnt + 4'd1;
      end
    end
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    exp_cnt   = '0;
    exp_ill   = 1'b0;
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = '0;
    @(posedge clk);
    #1;

    // Reset held: FETCH, everything quiet even with mem_ready high.
    push(1'b1, ST_FETCH, 1'b1, OP_R);
    push(1'b1, ST_FETCH, 1'b0, OP_R);
    play();

    // R-type with no waits, then LW with two waits in FETCH and MEM_READ.
    enqueue_instr(OP_R, 0, 0);
    play();
    check("after_R_count", 32'(retired_count), 32'd1);
    enqueue_instr(OP_LW, 2, 2);
    play();

    // SW/BEQ, an SW with one wait, JAL/JR.
    enqueue_instr(OP_SW, 0, 0);
    enqueue_instr(OP_BEQ, 0, 0);
    enqueue_instr(OP_SW, 1, 1);
    enqueue_instr(OP_JAL, 0, 0);
    enqueue_instr(OP_JR, 0, 0);
    play();

    // Illegal opcode: trapped for 10 cycles, then reset recovers to FETCH.
    enqueue_instr(OP_BAD, 0, 10);
    push(1'b1, ST_TRAP, 1'b1, OP_BAD);
    enqueue_instr(OP_R, 0, 0);
    play();

    // Reset while MEM_READ is waiting aborts the LW without retiring it.
    push(1'b0, ST_FETCH, 1'b1, OP_LW);
    push(1'b0, ST_DECODE, 1'b0, OP_LW);
    push(1'b0, ST_MEM_ADDR, 1'b0, OP_LW);
    push(1'b0, ST_MEM_READ, 1'b0, OP_LW);
    push(1'b1, ST_MEM_READ, 1'b1, OP_LW);
    play();
    check("abort_count", 32'(retired_count), 32'd0);

    // Counter wrap at CNT_W=4: 15 retirements, then the 16th wraps to 0.
    enqueue_instr(OP_R, 0, 0);
    for (int i = 0; i < 14; i++) enqueue_instr(OP_JR, 0, 0);
    play();
    check("pre_wrap_count", 32'(retired_count), 32'd15);
    enqueue_instr(OP_JR, 0, 0);
    play();
    check("wrap_count", 32'(retired_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore/Mealy control FSM that sequences the shared MIPS multicycle datapath (single memory port, single ALU, IR/MDR/ALUOut registers) through fetch, decode, execute, memory and writeback steps.
- Supports the codebase opcode set: R-type, LW, SW, BEQ, JAL, and JR (JR encoded as opcode 6'b001000).
- Stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions.
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero (BEQ).
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs register.
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mdr_write  output  1  MDR load.
- mem_to_reg  output  1  writeback data: 0 ALUOut, 1 MDR.
- reg_dst  output  1  dest: 0 rt, 1 rd.
- reg_write  output  1  register file write.
- link  output  1  force dest $31, data PC (JAL).
- alu_src_a  output  1  0 PC, 1 register A.
- alu_src_b  output  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
- state  output  4  current state encoding (debug).
- instr_retired  output  1  one-cycle pulse on an instruction's final cycle.
- retired_count  output  CNT_W  instructions retired since reset.
- illegal_op  output  1  sticky; unknown opcode decoded.

Behaviour:
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, JR_EXEC=10, TRAP=11.
- Reset, sampled at a clock edge while high:
  - state=FETCH, retired_count=0, illegal_op=0.
  - While reset is high, all control outputs are forced to 0 and instr_retired=0.
  - Reset mid-instruction aborts it with no retirement.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 000000 -> EXEC_R; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000011 -> JUMP; 001000 -> JR_EXEC.
  - Any other opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ if opcode=LW, else MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1, mdr_write=mem_ready.
  - Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; retire; go to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready; retire on the mem_ready cycle; go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; retire; go to FETCH.
- JUMP (JAL): pc_write=1, pc_source=10, reg_write=1, link=1; retire; go to FETCH. The PC already holds PC+4, so the link value is the return address.
- JR_EXEC: pc_write=1, pc_source=11; retire; go to FETCH.
- TRAP:
  - illegal_op set to 1 and held until reset.
  - FSM stays in TRAP; no memory or register activity; no retirement.
- Memory handshake:
  - mem_read/mem_write stay asserted, with a stable address select, until the cycle mem_ready=1.
  - mem_ready while no request is active is ignored.
- Retirement:
  - instr_retired pulses exactly once per instruction.
  - retired_count increments in the same cycle and wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied to 1:
  - R, BEQ, JAL, JR: 4, 3, 3, 3.
  - LW: 5. SW: 4.
  - Each wait cycle adds 1.

Test Plan:
- Reset then R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. In R_WB: reg_write=1, reg_dst=1. instr_retired pulses once; retired_count=1.
- LW (100011) with mem_ready low for 2 cycles in both FETCH and MEM_READ -> 9 cycles total. pc_write and ir_write only on the ready cycle. mdr_write=1 once. MEM_WB: mem_to_reg=1, reg_write=1.
- SW (101011) then BEQ (000100) -> SW: mem_write=1, i_or_d=1 in state 5 with no reg_write. BEQ: pc_write_cond=1, alu_op=01, pc_source=01. retired_count=2.
- JAL (000011) then JR (001000) -> JUMP: pc_source=10, link=1, reg_write=1. JR_EXEC: pc_source=11, pc_write=1, reg_write=0.
- Opcode 111111 -> TRAP (state=11). illegal_op=1 and held for 10 cycles. No mem_read. Synchronous reset clears it and returns to FETCH.
- Reset asserted in MEM_READ -> next state FETCH, all outputs 0 while reset high, retired_count=0. Preload retired_count to 2^CNT_W-1 (CNT_W=4, 15 instructions) -> 16th retirement wraps to 0.
